// File: rtl/gmux_sel_ctrl.sv
// Glitch-free GMUX select sequencer: gate the downstream clock, drain,
// flip the select, let the mux settle, then re-enable the gate.
module gmux_sel_ctrl #(
  parameter int DRAIN_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic QCK,
  input  logic QRT,
  input  logic req_valid,
  input  logic req_sel,
  input  logic cfg_lock,
  output logic req_ready,
  output logic IS0,
  output logic gate_en,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LD  = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       is0_q, is0_d;
  logic       gate_q, gate_d;
  logic       done_q, done_d;
  logic       accept;

  assign req_ready = (state_q == IDLE) && !cfg_lock;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    is0_d   = is0_q;
    gate_d  = gate_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_sel == is0_q) begin
            done_d = 1'b1;
          end else begin
            sel_d   = req_sel;
            cnt_d   = DRAIN_LD;
            gate_d  = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // select only moves once the gate has been low long enough
        if (cnt_q == 4'd0) begin
          is0_d   = sel_q;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          gate_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge QCK) begin
    if (QRT) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 1'b0;
      is0_q   <= 1'b0;
      gate_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      is0_q   <= is0_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
    end
  end

  assign IS0     = is0_q;
  assign gate_en = gate_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Directed bench for gmux_sel_ctrl: default timing instance plus a
// DRAIN=1/SETTLE=1 instance for the minimum-latency corner.
module tb_gmux_sel_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock = 1'b0;
  logic v0 = 1'b0, s0 = 1'b0;
  logic v1 = 1'b0, s1 = 1'b0;
  logic rdy0, is0_0, gate0, busy0, done0;
  logic rdy1, is0_1, gate1, busy1, done1;
  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  gmux_sel_ctrl u0 (
    .QCK(clk), .QRT(rst), .req_valid(v0), .req_sel(s0),
    .cfg_lock(lock), .req_ready(rdy0), .IS0(is0_0),
    .gate_en(gate0), .busy(busy0), .done(done0)
  );

  gmux_sel_ctrl #(.DRAIN_CYCLES(1), .SETTLE_CYCLES(1)) u1 (
    .QCK(clk), .QRT(rst), .req_valid(v1), .req_sel(s1),
    .cfg_lock(1'b0), .req_ready(rdy1), .IS0(is0_1),
    .gate_en(gate1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic is0,
                         input logic ge, input logic bz, input logic dn);
    chk({tag, ".IS0"}, is0_0, is0);
    chk({tag, ".gate_en"}, gate0, ge);
    chk({tag, ".busy"}, busy0, bz);
    chk({tag, ".done"}, done0, dn);
  endtask

  // Edge 0 (acceptance) already taken; walk edges 1..6 of a default switch.
  task automatic walk(input string tag, input logic old_sel,
                      input logic new_sel);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk_all($sformatf("%s.e%0d", tag, e),
              (e >= 2) ? new_sel : old_sel,
              e >= 5, e < 5, e == 5);
    end
  endtask

  initial begin
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset.req_ready", rdy0, 1'b1);

    // Minimum-latency instance.
    v1 = 1'b1; s1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("min.e0.gate_en", gate1, 1'b0);
    chk("min.e0.IS0", is0_1, 1'b0);
    chk("min.e0.busy", busy1, 1'b1);
    tick();
    chk("min.e1.IS0", is0_1, 1'b1);
    chk("min.e1.gate_en", gate1, 1'b0);
    tick();
    chk("min.e2.gate_en", gate1, 1'b1);
    chk("min.e2.done", done1, 1'b1);
    chk("min.e2.busy", busy1, 1'b0);
    tick();
    chk("min.e3.done", done1, 1'b0);

    // Same-select request: done pulse only.
    v0 = 1'b1; s0 = 1'b0;
    tick();
    v0 = 1'b0;
    chk_all("same.e0", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("same.e1", 1'b0, 1'b1, 1'b0, 1'b0);

    // Locked: request held but refused.
    lock = 1'b1; v0 = 1'b1; s0 = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("lock.c%0d.req_ready", i), rdy0, 1'b0);
      tick();
      chk_all($sformatf("lock.c%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    lock = 1'b0;
    #1;
    chk("unlock.req_ready", rdy0, 1'b1);
    tick();
    v0 = 1'b0;
    chk_all("sw1.e0", 1'b0, 1'b0, 1'b1, 1'b0);
    walk("sw1", 1'b0, 1'b1);

    // Lock raised mid-switch with a new request pending: switch completes.
    v0 = 1'b1; s0 = 1'b0;
    tick();
    chk_all("midlock.e0", 1'b1, 1'b0, 1'b1, 1'b0);
    lock = 1'b1; s0 = 1'b1;
    walk("midlock", 1'b1, 1'b0);
    chk("midlock.req_ready", rdy0, 1'b0);
    lock = 1'b0; v0 = 1'b0;

    // Back-to-back: 1 then 0, second presented on the done edge.
    v0 = 1'b1; s0 = 1'b1;
    tick();
    v0 = 1'b0;
    chk_all("b2b.a0", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 5; e++) tick();
    chk_all("b2b.a5", 1'b1, 1'b1, 1'b0, 1'b1);
    v0 = 1'b1; s0 = 1'b0;
    #1;
    chk("b2b.req_ready", rdy0, 1'b1);
    tick();
    v0 = 1'b0;
    chk_all("b2b.b0", 1'b1, 1'b0, 1'b1, 1'b0);
    walk("b2b.b", 1'b1, 1'b0);

    // Reset during SETTLE, with a request held across the reset edge.
    v0 = 1'b1; s0 = 1'b1;
    tick();
    v0 = 1'b0;
    tick(); tick(); tick();
    chk_all("rst.settle", 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; v0 = 1'b1;
    tick();
    chk_all("rst.e0", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0; v0 = 1'b0;
    #1;
    chk("rst.req_ready", rdy0, 1'b1);
    tick();
    chk_all("rst.e1", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
